// File: rtl/floatli_share_arbiter_pkg.sv
// Arbiter-local types and round-robin index helpers.
package floatli_share_arbiter_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return rr_wrap(idx + 1, n);
  endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// FPU type subset used by the shared-FPU arbiter: formats, round modes,
// operations, status flags and the feature-set descriptor.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS  = 5;
  localparam int unsigned NUM_INT_FORMATS = 4;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef logic [0:NUM_FP_FORMATS-1]  fmt_logic_t;
  typedef logic [0:NUM_INT_FORMATS-1] ifmt_logic_t;

  typedef struct packed {
    int unsigned Width;
    logic        EnableVectors;
    logic        EnableNanBox;
    fmt_logic_t  FpFmtMask;
    ifmt_logic_t IntFmtMask;
  } fpu_features_t;

  localparam fpu_features_t RV32F = '{
    Width:         32,
    EnableVectors: 1'b0,
    EnableNanBox:  1'b1,
    FpFmtMask:     5'b10000,
    IntFmtMask:    4'b0010
  };

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/floatli_rr_arb.sv
// Round-robin priority search: first valid requester at or after ptr_i,
// wrapping modulo NumReq.
module floatli_rr_arb
  import floatli_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdW    = 1
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [IdW-1:0]    gnt_idx_o,
  output logic              any_valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_idx_o   = '0;
    any_valid_o = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = rr_wrap(32'(ptr_i) + i, NumReq);
      if (!any_valid_o && valid_i[IdW'(idx)]) begin
        any_valid_o = 1'b1;
        gnt_idx_o   = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/floatli_share_arbiter.sv
// Shares one FPU among NumReq requesters: round-robin issue with grant lock
// under back-pressure, outstanding-op limit, tag-routed responses.
module floatli_share_arbiter
  import floatli_share_arbiter_pkg::*;
#(
  parameter fpnew_pkg::fpu_features_t Features       = fpnew_pkg::RV32F,
  parameter int unsigned              NumReq         = 2,
  parameter int unsigned              MaxOutstanding = 2,
  parameter type                      TagType        = logic
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NumReq-1:0]                           req_valid_i,
  output logic [NumReq-1:0]                           req_ready_o,
  input  logic [NumReq-1:0][2:0][Features.Width-1:0]  req_operands_i,
  input  fpnew_pkg::roundmode_e  [NumReq-1:0]         req_rnd_mode_i,
  input  fpnew_pkg::operation_e  [NumReq-1:0]         req_op_i,
  input  logic [NumReq-1:0]                           req_op_mod_i,
  input  fpnew_pkg::fp_format_e  [NumReq-1:0]         req_src_fmt_i,
  input  fpnew_pkg::fp_format_e  [NumReq-1:0]         req_dst_fmt_i,
  input  fpnew_pkg::int_format_e [NumReq-1:0]         req_int_fmt_i,
  input  TagType [NumReq-1:0]                         req_tag_i,
  output logic [NumReq-1:0]                           rsp_valid_o,
  input  logic [NumReq-1:0]                           rsp_ready_i,
  output logic [Features.Width-1:0]                   rsp_result_o,
  output fpnew_pkg::status_t                          rsp_status_o,
  output TagType                                      rsp_tag_o,
  output logic                                        fpu_in_valid_o,
  input  logic                                        fpu_in_ready_i,
  output logic [2:0][Features.Width-1:0]              fpu_operands_o,
  output fpnew_pkg::roundmode_e                       fpu_rnd_mode_o,
  output fpnew_pkg::operation_e                       fpu_op_o,
  output logic                                        fpu_op_mod_o,
  output fpnew_pkg::fp_format_e                       fpu_src_fmt_o,
  output fpnew_pkg::fp_format_e                       fpu_dst_fmt_o,
  output fpnew_pkg::int_format_e                      fpu_int_fmt_o,
  output logic [$clog2(NumReq)+$bits(TagType)-1:0]    fpu_tag_o,
  input  logic                                        fpu_out_valid_i,
  output logic                                        fpu_out_ready_o,
  input  logic [Features.Width-1:0]                   fpu_result_i,
  input  fpnew_pkg::status_t                          fpu_status_i,
  input  logic [$clog2(NumReq)+$bits(TagType)-1:0]    fpu_tag_i,
  input  logic                                        fpu_busy_i,
  input  logic                                        flush_i,
  output logic                                        fpu_flush_o,
  output logic                                        busy_o
);

  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  // Tag carried through the FPU; id routes the response back.
  typedef struct packed {
    logic [IdW-1:0] id;
    TagType         tag;
  } fpu_tag_t;

  arb_state_e      state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  lock_id_q, lock_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdW-1:0]  arb_idx;
  logic            arb_any;
  logic [IdW-1:0]  grant;
  logic            gnt_valid;
  logic            cnt_full;
  logic            in_hs;
  logic            out_hs;
  logic            rsp_sel_ready;
  fpu_tag_t        out_tag;
  fpu_tag_t        in_tag;

  floatli_rr_arb #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) u_rr_arb (
    .valid_i     (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_o   (arb_idx),
    .any_valid_o (arb_any)
  );

  assign grant     = (state_q == ST_LOCK) ? lock_id_q : arb_idx;
  assign gnt_valid = (state_q == ST_LOCK) ? req_valid_i[lock_id_q] : arb_any;
  assign cnt_full  = (cnt_q >= CntW'(MaxOutstanding));

  // Gated by rst_ni so nothing handshakes while reset is held.
  assign fpu_in_valid_o = rst_ni & gnt_valid & ~cnt_full & ~flush_i;
  assign in_hs          = fpu_in_valid_o & fpu_in_ready_i;

  assign fpu_operands_o = req_operands_i[grant];
  assign fpu_rnd_mode_o = req_rnd_mode_i[grant];
  assign fpu_op_o       = req_op_i[grant];
  assign fpu_op_mod_o   = req_op_mod_i[grant];
  assign fpu_src_fmt_o  = req_src_fmt_i[grant];
  assign fpu_dst_fmt_o  = req_dst_fmt_i[grant];
  assign fpu_int_fmt_o  = req_int_fmt_i[grant];

  assign out_tag.id  = grant;
  assign out_tag.tag = req_tag_i[grant];
  assign fpu_tag_o   = out_tag;

  assign in_tag = fpu_tag_i;

  always_comb begin
    req_ready_o   = '0;
    rsp_valid_o   = '0;
    rsp_sel_ready = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = in_hs && (grant == IdW'(i));
      rsp_valid_o[i] = rst_ni && fpu_out_valid_i && (in_tag.id == IdW'(i));
      if (in_tag.id == IdW'(i)) begin
        rsp_sel_ready = rsp_ready_i[i];
      end
    end
  end

  assign fpu_out_ready_o = rst_ni & rsp_sel_ready;
  assign out_hs          = fpu_out_valid_i & fpu_out_ready_o;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign rsp_tag_o       = in_tag.tag;

  assign fpu_flush_o = flush_i;
  assign busy_o      = (cnt_q != '0) | fpu_busy_i;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_ARB: begin
        if (fpu_in_valid_o && !fpu_in_ready_i) begin
          state_d   = ST_LOCK;
          lock_id_d = grant;
        end
      end
      ST_LOCK: begin
        if (in_hs) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (in_hs) begin
      rr_ptr_d = IdW'(rr_next(32'(grant), NumReq));
    end

    // Flush wins over any handshake bookkeeping; rr_ptr is intentionally kept.
    if (flush_i) begin
      cnt_d   = '0;
      state_d = ST_ARB;
    end else if (in_hs && !out_hs) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!in_hs && out_hs) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(out_hs && (cnt_q == '0)));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q <= CntW'(MaxOutstanding)));

endmodule

// File: tb/tb_floatli_share_arbiter.sv
// Scoreboard bench for floatli_share_arbiter (NumReq=2, MaxOutstanding=2).
module tb_floatli_share_arbiter;
  import fpnew_pkg::*;
  import floatli_share_arbiter_pkg::*;

  logic                  clk_i;
  logic                  rst_ni;
  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0][2:0][31:0] req_operands_i;
  roundmode_e  [1:0]     req_rnd_mode_i;
  operation_e  [1:0]     req_op_i;
  logic [1:0]            req_op_mod_i;
  fp_format_e  [1:0]     req_src_fmt_i;
  fp_format_e  [1:0]     req_dst_fmt_i;
  int_format_e [1:0]     req_int_fmt_i;
  logic [1:0]            req_tag_i;
  logic [1:0]            rsp_valid_o;
  logic [1:0]            rsp_ready_i;
  logic [31:0]           rsp_result_o;
  status_t               rsp_status_o;
  logic                  rsp_tag_o;
  logic                  fpu_in_valid_o;
  logic                  fpu_in_ready_i;
  logic [2:0][31:0]      fpu_operands_o;
  roundmode_e            fpu_rnd_mode_o;
  operation_e            fpu_op_o;
  logic                  fpu_op_mod_o;
  fp_format_e            fpu_src_fmt_o;
  fp_format_e            fpu_dst_fmt_o;
  int_format_e           fpu_int_fmt_o;
  logic [1:0]            fpu_tag_o;
  logic                  fpu_out_valid_i;
  logic                  fpu_out_ready_o;
  logic [31:0]           fpu_result_i;
  status_t               fpu_status_i;
  logic [1:0]            fpu_tag_i;
  logic                  fpu_busy_i;
  logic                  flush_i;
  logic                  fpu_flush_o;
  logic                  busy_o;

  floatli_share_arbiter #(
    .Features       (fpnew_pkg::RV32F),
    .NumReq         (2),
    .MaxOutstanding (2),
    .TagType        (logic)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_operands_i  (req_operands_i),
    .req_rnd_mode_i  (req_rnd_mode_i),
    .req_op_i        (req_op_i),
    .req_op_mod_i    (req_op_mod_i),
    .req_src_fmt_i   (req_src_fmt_i),
    .req_dst_fmt_i   (req_dst_fmt_i),
    .req_int_fmt_i   (req_int_fmt_i),
    .req_tag_i       (req_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_status_o    (rsp_status_o),
    .rsp_tag_o       (rsp_tag_o),
    .fpu_in_valid_o  (fpu_in_valid_o),
    .fpu_in_ready_i  (fpu_in_ready_i),
    .fpu_operands_o  (fpu_operands_o),
    .fpu_rnd_mode_o  (fpu_rnd_mode_o),
    .fpu_op_o        (fpu_op_o),
    .fpu_op_mod_o    (fpu_op_mod_o),
    .fpu_src_fmt_o   (fpu_src_fmt_o),
    .fpu_dst_fmt_o   (fpu_dst_fmt_o),
    .fpu_int_fmt_o   (fpu_int_fmt_o),
    .fpu_tag_o       (fpu_tag_o),
    .fpu_out_valid_i (fpu_out_valid_i),
    .fpu_out_ready_o (fpu_out_ready_o),
    .fpu_result_i    (fpu_result_i),
    .fpu_status_i    (fpu_status_i),
    .fpu_tag_i       (fpu_tag_i),
    .fpu_busy_i      (fpu_busy_i),
    .flush_i         (flush_i),
    .fpu_flush_o     (fpu_flush_o),
    .busy_o          (busy_o)
  );

  typedef struct {
    logic [1:0]  tagv;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  op;
    logic [2:0]  rnd;
    logic [8:0]  fields;
    logic [1:0]  rdy;
  } in_exp_t;

  typedef struct {
    logic [1:0]  vld;
    logic        ordy;
    logic [31:0] res;
    logic        tag;
    logic [4:0]  st;
  } rsp_exp_t;

  in_exp_t  in_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0;
  int passes = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Hand-computed issue expectations; req0 tag=1, req1 tag=0.
  task automatic push_in(input int id);
    in_exp_t e;
    if (id == 0) begin
      e.tagv = 2'b01; e.op0 = 32'hA000_0000; e.op1 = 32'hA000_0010; e.op2 = 32'hA000_0020;
      e.op = 4'd2; e.rnd = 3'b000; e.fields = 9'b0_000_000_10; e.rdy = 2'b01;
    end else begin
      e.tagv = 2'b10; e.op0 = 32'hA000_0001; e.op1 = 32'hA000_0011; e.op2 = 32'hA000_0021;
      e.op = 4'd3; e.rnd = 3'b001; e.fields = 9'b1_010_001_11; e.rdy = 2'b10;
    end
    in_q.push_back(e);
  endtask

  task automatic push_rsp(input logic [1:0] vld, input logic ordy, input logic [31:0] res,
                          input logic tag, input logic [4:0] st);
    rsp_exp_t e;
    e.vld = vld; e.ordy = ordy; e.res = res; e.tag = tag; e.st = st;
    rsp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin : in_monitor
    in_exp_t e;
    forever begin
      @(negedge clk_i);
      if (fpu_in_valid_o && fpu_in_ready_i) begin
        if (in_q.size() == 0) begin
          checks++;
          $display("FAIL in_unexpected: issue with tag %0h, nothing expected at %0t", fpu_tag_o, $time);
        end else begin
          e = in_q.pop_front();
          chk("in_tag",    64'(fpu_tag_o),         64'(e.tagv));
          chk("in_op0",    64'(fpu_operands_o[0]), 64'(e.op0));
          chk("in_op1",    64'(fpu_operands_o[1]), 64'(e.op1));
          chk("in_op2",    64'(fpu_operands_o[2]), 64'(e.op2));
          chk("in_op",     64'(fpu_op_o),          64'(e.op));
          chk("in_rnd",    64'(fpu_rnd_mode_o),    64'(e.rnd));
          chk("in_fields", 64'({fpu_op_mod_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o}),
              64'(e.fields));
          chk("req_ready", 64'(req_ready_o),       64'(e.rdy));
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_exp_t e;
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o != 2'b00) begin
        if (rsp_q.size() == 0) begin
          checks++;
          $display("FAIL rsp_unexpected: rsp_valid_o=%b, nothing expected at %0t", rsp_valid_o, $time);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_valid",  64'(rsp_valid_o),     64'(e.vld));
          chk("rsp_oready", 64'(fpu_out_ready_o), 64'(e.ordy));
          chk("rsp_result", 64'(rsp_result_o),    64'(e.res));
          chk("rsp_tag",    64'(rsp_tag_o),       64'(e.tag));
          chk("rsp_status", 64'(rsp_status_o),    64'(e.st));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    rst_ni = 1'b0;
    req_valid_i = 2'b00; fpu_in_ready_i = 1'b0; rsp_ready_i = 2'b00;
    fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = 2'b00;
    fpu_busy_i = 1'b0; flush_i = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++)
        req_operands_i[r][k] = 32'hA000_0000 | 32'(k << 4) | 32'(r);
    req_rnd_mode_i[0] = RNE;   req_rnd_mode_i[1] = RTZ;
    req_op_i[0]       = ADD;   req_op_i[1]       = MUL;
    req_src_fmt_i[0]  = FP32;  req_src_fmt_i[1]  = FP16;
    req_dst_fmt_i[0]  = FP32;  req_dst_fmt_i[1]  = FP64;
    req_int_fmt_i[0]  = INT32; req_int_fmt_i[1]  = INT64;
    req_op_mod_i = 2'b10;
    req_tag_i    = 2'b01;

    // Reset: outputs inert even with requests pending
    #2;
    req_valid_i = 2'b11; fpu_in_ready_i = 1'b1; fpu_busy_i = 1'b1;
    #1;
    chk("rst_in_valid",  64'(fpu_in_valid_o), 64'(0));
    chk("rst_req_ready", 64'(req_ready_o),    64'(0));
    chk("rst_busy_hi",   64'(busy_o),         64'(1));
    chk("rst_state",     64'(dut.state_q),    64'(ST_ARB));
    chk("rst_rr",        64'(dut.rr_ptr_q),   64'(0));
    chk("rst_lock",      64'(dut.lock_id_q),  64'(0));
    chk("rst_cnt",       64'(dut.cnt_q),      64'(0));
    fpu_busy_i = 1'b0;
    #1;
    chk("rst_busy_lo",   64'(busy_o),         64'(0));
    req_valid_i = 2'b00; fpu_in_ready_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Alternating grants until the outstanding limit
    step(); req_valid_i = 2'b11; fpu_in_ready_i = 1'b1; push_in(0);
    @(negedge clk_i); chk("alt_cnt0", 64'(dut.cnt_q), 64'(0));
    step(); push_in(1);
    @(negedge clk_i); chk("alt_cnt1", 64'(dut.cnt_q), 64'(1)); chk("alt_rr1", 64'(dut.rr_ptr_q), 64'(1));
    step();
    @(negedge clk_i);
    chk("full_in_valid", 64'(fpu_in_valid_o), 64'(0));
    chk("full_cnt",      64'(dut.cnt_q),      64'(2));
    chk("full_rr",       64'(dut.rr_ptr_q),   64'(0));
    chk("full_busy",     64'(busy_o),         64'(1));
    chk("full_state",    64'(dut.state_q),    64'(ST_ARB));

    // Response to req1 stalled by its ready, then accepted
    step(); req_valid_i = 2'b00; fpu_in_ready_i = 1'b0;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'b11; fpu_result_i = 32'hDEAD_0001;
    fpu_status_i = 5'b00001; rsp_ready_i = 2'b01;
    push_rsp(2'b10, 1'b0, 32'hDEAD_0001, 1'b1, 5'b00001);
    @(negedge clk_i); chk("rsp_stall_cnt", 64'(dut.cnt_q), 64'(2));
    step(); rsp_ready_i = 2'b11;
    push_rsp(2'b10, 1'b1, 32'hDEAD_0001, 1'b1, 5'b00001);
    @(negedge clk_i);
    step(); fpu_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
    @(negedge clk_i); chk("rsp_dec_cnt", 64'(dut.cnt_q), 64'(1));

    // Simultaneous issue and retire at outstanding=1
    step(); req_valid_i = 2'b01; fpu_in_ready_i = 1'b1; push_in(0);
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'b00; fpu_result_i = 32'hCAFE_0000;
    fpu_status_i = 5'b10000; rsp_ready_i = 2'b01;
    push_rsp(2'b01, 1'b1, 32'hCAFE_0000, 1'b0, 5'b10000);
    @(negedge clk_i);
    step(); req_valid_i = 2'b00; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
    @(negedge clk_i);
    chk("both_cnt", 64'(dut.cnt_q),    64'(1));
    chk("both_rr",  64'(dut.rr_ptr_q), 64'(1));

    // Drain to zero
    step(); fpu_out_valid_i = 1'b1; fpu_tag_i = 2'b01; fpu_result_i = 32'h0000_BEEF;
    fpu_status_i = 5'b00000; rsp_ready_i = 2'b01;
    push_rsp(2'b01, 1'b1, 32'h0000_BEEF, 1'b1, 5'b00000);
    @(negedge clk_i);
    step(); fpu_out_valid_i = 1'b0; rsp_ready_i = 2'b00;
    @(negedge clk_i);
    chk("drain_cnt",  64'(dut.cnt_q), 64'(0));
    chk("drain_busy", 64'(busy_o),    64'(0));

    // Lock on req0 under back-pressure while req1 competes (rr_ptr=1)
    step(); req_valid_i = 2'b01; fpu_in_ready_i = 1'b0;
    @(negedge clk_i);
    chk("lk1_grant",  64'(fpu_tag_o),      64'(2'b01));
    chk("lk1_valid",  64'(fpu_in_valid_o), 64'(1));
    chk("lk1_ready",  64'(req_ready_o),    64'(0));
    step(); req_valid_i = 2'b11;
    @(negedge clk_i);
    chk("lk2_state",  64'(dut.state_q),   64'(ST_LOCK));
    chk("lk2_id",     64'(dut.lock_id_q), 64'(0));
    chk("lk2_grant",  64'(fpu_tag_o),     64'(2'b01));
    step();
    @(negedge clk_i);
    chk("lk3_grant",  64'(fpu_tag_o),     64'(2'b01));
    chk("lk3_ready",  64'(req_ready_o),   64'(0));
    step(); fpu_in_ready_i = 1'b1; push_in(0);
    @(negedge clk_i);
    step(); req_valid_i = 2'b10; push_in(1);
    @(negedge clk_i);
    chk("lk5_rr",     64'(dut.rr_ptr_q), 64'(1));
    chk("lk5_state",  64'(dut.state_q),  64'(ST_ARB));
    chk("lk5_cnt",    64'(dut.cnt_q),    64'(1));

    // Flush at outstanding=2
    step(); req_valid_i = 2'b01; fpu_in_ready_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    chk("fa_cnt_pre",  64'(dut.cnt_q),      64'(2));
    chk("fa_flush_o",  64'(fpu_flush_o),    64'(1));
    chk("fa_in_valid", 64'(fpu_in_valid_o), 64'(0));
    step(); flush_i = 1'b0; req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("fa_cnt",      64'(dut.cnt_q),   64'(0));
    chk("fa_flush_lo", 64'(fpu_flush_o), 64'(0));
    chk("fa_rr",       64'(dut.rr_ptr_q), 64'(0));

    // Flush while locked with one in flight; rr_ptr=1 must survive
    step(); req_valid_i = 2'b01; fpu_in_ready_i = 1'b1; push_in(0);
    @(negedge clk_i);
    step(); req_valid_i = 2'b10; fpu_in_ready_i = 1'b0;
    @(negedge clk_i); chk("fb_grant", 64'(fpu_tag_o), 64'(2'b10));
    step(); req_valid_i = 2'b11; flush_i = 1'b1;
    @(negedge clk_i);
    chk("fb_state_pre", 64'(dut.state_q),    64'(ST_LOCK));
    chk("fb_cnt_pre",   64'(dut.cnt_q),      64'(1));
    chk("fb_flush_o",   64'(fpu_flush_o),    64'(1));
    chk("fb_in_valid",  64'(fpu_in_valid_o), 64'(0));
    step(); flush_i = 1'b0; req_valid_i = 2'b00;
    @(negedge clk_i);
    chk("fb_state", 64'(dut.state_q),  64'(ST_ARB));
    chk("fb_cnt",   64'(dut.cnt_q),    64'(0));
    chk("fb_rr",    64'(dut.rr_ptr_q), 64'(1));

    // Asynchronous reset mid-transfer
    step(); req_valid_i = 2'b01; fpu_in_ready_i = 1'b1; push_in(0);
    @(negedge clk_i);
    step(); req_valid_i = 2'b10; fpu_in_ready_i = 1'b0;
    @(negedge clk_i);
    step();
    @(negedge clk_i);
    chk("mr_state_pre", 64'(dut.state_q),   64'(ST_LOCK));
    chk("mr_lock_pre",  64'(dut.lock_id_q), 64'(1));
    chk("mr_rr_pre",    64'(dut.rr_ptr_q),  64'(1));
    chk("mr_cnt_pre",   64'(dut.cnt_q),     64'(1));
    #1 rst_ni = 1'b0; fpu_in_ready_i = 1'b1;
    #1;
    chk("mr_state",     64'(dut.state_q),      64'(ST_ARB));
    chk("mr_rr",        64'(dut.rr_ptr_q),     64'(0));
    chk("mr_lock",      64'(dut.lock_id_q),    64'(0));
    chk("mr_cnt",       64'(dut.cnt_q),        64'(0));
    chk("mr_req_ready", 64'(req_ready_o),      64'(0));
    chk("mr_in_valid",  64'(fpu_in_valid_o),   64'(0));
    step(); req_valid_i = 2'b00; fpu_in_ready_i = 1'b0;
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("in_q_empty",  64'(in_q.size()),  64'(0));
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
